sistema_empotrado_nodo: RTL and testbench

// Top-level packet node for the FPGA board. Three 8N1 UART ports (A, B, C) carry 1-byte packets {data[7:4], dest[3:0]}.

---
 rtl/sistema_empotrado_nodo.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_sistema_empotrado_nodo.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sistema_empotrado_nodo.sv
// Three-port UART ring node: consumes packets addressed to its own ID, forwards the rest
// round the ring (A->B->C->A), and injects a switch-defined packet on port A from BTN0.

module nodo_uart_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk_100m_i,
    input  logic       rst_i,
    input  logic       rx,
    output logic       done,
    output logic [7:0] data
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          active, rx_prev;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;  // 0: start re-check, 1..8: data bits, 9: stop bit

    always_ff @(posedge clk_100m_i or negedge rst_i) begin
        if (!rst_i) begin
            active  <= 1'b0;
            rx_prev <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
            done    <= 1'b0;
            data    <= '0;
        end else begin
            done    <= 1'b0;
            rx_prev <= rx;
            if (!active) begin
                if (rx_prev && !rx) begin
                    active <= 1'b1;
                    cnt    <= '0;
                    idx    <= '0;
                end
            end else if (idx == 4'd0) begin
                if (cnt == HALF) begin
                    cnt <= '0;
                    if (rx) active <= 1'b0;
                    else    idx    <= 4'd1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt == LAST) begin
                cnt <= '0;
                if (idx == 4'd9) begin
                    active <= 1'b0;
                    done   <= rx;
                end else begin
                    data <= {rx, data[7:1]};
                    idx  <= idx + 4'd1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module nodo_uart_tx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk_100m_i,
    input  logic       rst_i,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    n;

    // Handshake: start is taken only in a cycle where busy is low; busy rises the next cycle
    // and stays high for the whole 10-bit frame. rx done is a 1-cycle strobe, data holds until the next frame.
    always_ff @(posedge clk_100m_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg <= '1;
            cnt   <= '0;
            n     <= '0;
            busy  <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                shreg <= {1'b1, data, 1'b0};
                cnt   <= '0;
                n     <= '0;
            end
        end else if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {1'b1, shreg[9:1]};
            if (n == 4'd9) busy <= 1'b0;
            else           n    <= n + 4'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tx = shreg[0];
endmodule

module sistema_empotrado_nodo #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD,
    parameter int REFRESH_CLKS = 100_000
) (
    input  logic        clk_100m_i,
    input  logic        rst_i,
    input  logic [19:0] sw_bt_i,
    input  logic        rx_a_i,
    input  logic        rx_b_i,
    input  logic        rx_c_i,
    output logic [15:0] leds_o,
    output logic [7:0]  an_o,
    output logic [7:0]  seg_o,
    output logic        tx_a_o,
    output logic        tx_b_o,
    output logic        tx_c_o
);
    typedef enum logic [2:0] {REPOSO, PROCESAMIENTO, CONSUMIR, RETRANSMITIR, GENERACION} state_t;

    localparam int RW = $clog2(REFRESH_CLKS + 1);
    localparam logic [RW-1:0] RLAST = RW'(REFRESH_CLKS - 1);

    logic [2:0]  rx_meta, rx_sync;
    logic [11:0] sw_meta, sw_sync;
    logic        btn_meta, btn_sync, btn_prev, btn_pulse;
    logic        sw_unused;

    assign sw_unused = ^{sw_bt_i[19:17], sw_bt_i[15:12]};
    assign btn_pulse = btn_sync & ~btn_prev;

    always_ff @(posedge clk_100m_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta  <= '1;
            rx_sync  <= '1;
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            rx_meta  <= {rx_c_i, rx_b_i, rx_a_i};
            rx_sync  <= rx_meta;
            sw_meta  <= sw_bt_i[11:0];
            sw_sync  <= sw_meta;
            btn_meta <= sw_bt_i[16];
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    // Port index 0/1/2 = A/B/C throughout
    logic [2:0] rx_done, tx_start, tx_busy, tx_line;
    logic [7:0] rx_data [3];
    logic [7:0] tx_data;

    genvar g;
    for (g = 0; g < 3; g = g + 1) begin : g_port
        nodo_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
            .clk_100m_i(clk_100m_i), .rst_i(rst_i), .rx(rx_sync[g]),
            .done(rx_done[g]), .data(rx_data[g])
        );
        nodo_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
            .clk_100m_i(clk_100m_i), .rst_i(rst_i), .start(tx_start[g]),
            .data(tx_data), .tx(tx_line[g]), .busy(tx_busy[g])
        );
    end

    assign tx_a_o = tx_line[0];
    assign tx_b_o = tx_line[1];
    assign tx_c_o = tx_line[2];

    logic [7:0] buf_data [3];
    logic [2:0] buf_valid, take, src_q, tgt_oh;
    logic [7:0] sel_byte, byte_q, last_q;
    logic [3:0] count_q, state_leds, led_state_q;
    state_t     state_q, state_d;

    // Ring target is the source rotated one port onward: A->B, B->C, C->A
    assign tgt_oh  = {src_q[1:0], src_q[2]};
    assign tx_data = (state_q == GENERACION) ? sw_sync[7:0] : byte_q;

    always_comb begin
        state_d    = state_q;
        take       = '0;
        tx_start   = '0;
        sel_byte   = buf_data[2];
        state_leds = 4'b0001;
        case (state_q)
            REPOSO: begin
                if      (buf_valid[0]) begin take = 3'b001; sel_byte = buf_data[0]; end
                else if (buf_valid[1]) begin take = 3'b010; sel_byte = buf_data[1]; end
                else if (buf_valid[2]) begin take = 3'b100; sel_byte = buf_data[2]; end
                if (|buf_valid)                      state_d = PROCESAMIENTO;
                else if (btn_pulse && !tx_busy[0])   state_d = GENERACION;
            end
            PROCESAMIENTO: begin
                state_leds = 4'b0010;
                state_d    = (byte_q[3:0] == sw_sync[11:8]) ? CONSUMIR : RETRANSMITIR;
            end
            CONSUMIR: begin
                state_leds = 4'b0100;
                state_d    = REPOSO;
            end
            RETRANSMITIR: begin
                state_leds = 4'b0100;
                if (!(|(tx_busy & tgt_oh))) begin
                    tx_start = tgt_oh;
                    state_d  = REPOSO;
                end
            end
            GENERACION: begin
                state_leds = 4'b1000;
                if (!tx_busy[0]) begin
                    tx_start = 3'b001;
                    state_d  = REPOSO;
                end
            end
            default: state_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk_100m_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= REPOSO;
            led_state_q <= '0;
            buf_valid   <= '0;
            byte_q      <= '0;
            src_q       <= 3'b001;
            last_q      <= '0;
            count_q     <= '0;
            for (int i = 0; i < 3; i++) buf_data[i] <= '0;
        end else begin
            state_q     <= state_d;
            led_state_q <= state_leds;
            // A byte landing in the same cycle it is taken stays pending: set wins over clear
            for (int i = 0; i < 3; i++) begin
                if (rx_done[i]) begin
                    buf_data[i]  <= rx_data[i];
                    buf_valid[i] <= 1'b1;
                end else if (take[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
            if (|take) begin
                byte_q <= sel_byte;
                src_q  <= take;
            end
            if (state_q == CONSUMIR) begin
                last_q  <= byte_q;
                count_q <= count_q + 4'd1;
            end
        end
    end

    assign leds_o = {led_state_q, count_q, last_q};

    logic [RW-1:0] refresh_q;
    logic [2:0]    digit_q;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    font;

    always_comb begin
        nib   = 4'h0;
        blank = 1'b1;
        case (digit_q)
            3'd0: begin nib = last_q[3:0];   blank = 1'b0; end
            3'd1: begin nib = last_q[7:4];   blank = 1'b0; end
            3'd4: begin nib = sw_sync[11:8]; blank = 1'b0; end
            default: ;
        endcase
        case (nib)
            4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
            4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
            4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
            4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
        endcase
    end

    always_ff @(posedge clk_100m_i or negedge rst_i) begin
        if (!rst_i) begin
            refresh_q <= '0;
            digit_q   <= '0;
            an_o      <= 8'hFF;
            seg_o     <= 8'hFF;
        end else begin
            if (refresh_q == RLAST) begin
                refresh_q <= '0;
                digit_q   <= digit_q + 3'd1;
            end else begin
                refresh_q <= refresh_q + RW'(1);
            end
            an_o  <= ~(8'd1 << digit_q);
            seg_o <= blank ? 8'hFF : {1'b1, ~font};
        end
    end
endmodule

// File: tb/tb_sistema_empotrado_nodo.sv
// Directed bench for the ring node: reset state, consume, forward, generate, arbitration,
// bad frames, mid-frame reset, count wrap and 7-seg scan.

module tb_sistema_empotrado_nodo;
    localparam int CPB = 16;
    localparam int REF = 20;

    logic        clk_100m_i = 1'b0;
    logic        rst_i;
    logic [19:0] sw_bt_i;
    logic        rx_a_i, rx_b_i, rx_c_i;
    logic [15:0] leds_o;
    logic [7:0]  an_o, seg_o;
    logic        tx_a_o, tx_b_o, tx_c_o;
    logic [2:0]  tx_vec;

    int tests_run    = 0;
    int tests_failed = 0;
    int rst_count    = 0;

    // Entries are {port[1:0], byte}; port 3 marks a malformed frame
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    sistema_empotrado_nodo #(.CLKS_PER_BIT(CPB), .REFRESH_CLKS(REF)) dut (
        .clk_100m_i(clk_100m_i), .rst_i(rst_i), .sw_bt_i(sw_bt_i),
        .rx_a_i(rx_a_i), .rx_b_i(rx_b_i), .rx_c_i(rx_c_i),
        .leds_o(leds_o), .an_o(an_o), .seg_o(seg_o),
        .tx_a_o(tx_a_o), .tx_b_o(tx_b_o), .tx_c_o(tx_c_o)
    );

    always #5 clk_100m_i = ~clk_100m_i;
    assign tx_vec = {tx_c_o, tx_b_o, tx_a_o};
    always @(negedge rst_i) rst_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_100m_i);
    endtask

    task automatic mon(input int p);
        logic [7:0] d;
        logic       ok;
        int         rc;
        forever begin
            @(negedge clk_100m_i);
            if (rst_i === 1'b1 && tx_vec[p] === 1'b0) begin
                ok = 1'b1;
                rc = rst_count;
                d  = '0;
                repeat (CPB / 2) @(negedge clk_100m_i);
                if (tx_vec[p] !== 1'b0) ok = 1'b0;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk_100m_i);
                    d[b] = tx_vec[p];
                end
                repeat (CPB) @(negedge clk_100m_i);
                if (tx_vec[p] !== 1'b1) ok = 1'b0;
                if (rc == rst_count) got_q.push_back(ok ? {p[1:0], d} : {2'b11, d});
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    task automatic send_frame(input logic [2:0] mask, input logic [7:0] da, input logic [7:0] db,
                              input logic [7:0] dc, input logic stop);
        logic [9:0] fa, fb, fc;
        fa = {stop, da, 1'b0};
        fb = {stop, db, 1'b0};
        fc = {stop, dc, 1'b0};
        for (int b = 0; b < 10; b++) begin
            if (mask[0]) rx_a_i = fa[b];
            if (mask[1]) rx_b_i = fb[b];
            if (mask[2]) rx_c_i = fc[b];
            idle(CPB);
        end
        rx_a_i = 1'b1;
        rx_b_i = 1'b1;
        rx_c_i = 1'b1;
    endtask

    task automatic check_frames(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // Aligns to the first cycle of digit 0's slot; an expired bound shows up as a failed check
    task automatic wait_digit0(input string tag);
        int k = 0;
        while (an_o === 8'hFE && k < 2 * REF) begin idle(1); k++; end
        k = 0;
        while (an_o !== 8'hFE && k < 10 * REF) begin idle(1); k++; end
        check(tag, an_o, 8'hFE);
    endtask

    initial begin
        rst_i   = 1'b0;
        sw_bt_i = '0;
        rx_a_i  = 1'b1;
        rx_b_i  = 1'b1;
        rx_c_i  = 1'b1;
        idle(5);
        check("rst_leds", leds_o, 16'h0000);
        check("rst_an",   an_o,   8'hFF);
        check("rst_seg",  seg_o,  8'hFF);
        check("rst_tx",   tx_vec, 3'b111);

        rst_i = 1'b1;
        idle(3);
        check("idle_leds", leds_o, 16'h1000);

        // Idle scan: digit 0/1 show "00", digit 4 the ID, digit 5 blank
        sw_bt_i = 20'h00200;
        idle(400);
        wait_digit0("idle_an0");
        check("idle_seg0", seg_o, 8'hC0);
        idle(REF);
        check("idle_an1", an_o, 8'hFD);
        check("idle_seg1", seg_o, 8'hC0);
        idle(3 * REF);
        check("idle_an4", an_o, 8'hEF);
        check("idle_seg4", seg_o, 8'hA4);
        idle(REF);
        check("idle_an5", an_o, 8'hDF);
        check("idle_seg5", seg_o, 8'hFF);
        check("idle_tx", tx_vec, 3'b111);
        check_frames("idle_frames");

        // Consume 0xA2 on A
        send_frame(3'b001, 8'hA2, 8'h00, 8'h00, 1'b1);
        idle(4);
        check("cons_leds", leds_o, 16'h11A2);
        wait_digit0("cons_an0");
        check("cons_seg0", seg_o, 8'hA4);
        idle(REF);
        check("cons_seg1", seg_o, 8'h88);
        check_frames("cons_frames");

        // Forward 0x58 from B to C
        send_frame(3'b010, 8'h00, 8'h58, 8'h00, 1'b1);
        exp_q.push_back({2'd2, 8'h58});
        idle(CPB * 12);
        check("fwd_leds", leds_o, 16'h11A2);
        check_frames("fwd_frames");

        // Two BTN0 presses 200 ns apart produce one 0x30 frame on A
        sw_bt_i = 20'h00230;
        idle(5);
        sw_bt_i = 20'h10230; idle(3);
        sw_bt_i = 20'h00230; idle(17);
        sw_bt_i = 20'h10230; idle(3);
        sw_bt_i = 20'h00230;
        exp_q.push_back({2'd0, 8'h30});
        idle(CPB * 12);
        check("gen_leds", leds_o, 16'h11A2);
        check_frames("gen_frames");

        // Simultaneous A and C: A consumed first, C forwarded on A
        send_frame(3'b101, 8'h12, 8'h00, 8'h13, 1'b1);
        idle(4);
        check("arb_leds", leds_o, 16'h1212);
        exp_q.push_back({2'd0, 8'h13});
        idle(CPB * 12);
        check_frames("arb_frames");

        // Stop bit low, then a start glitch on B: both dropped
        send_frame(3'b001, 8'h22, 8'h00, 8'h00, 1'b0);
        idle(4);
        rx_b_i = 1'b0; idle(3);
        rx_b_i = 1'b1;
        idle(CPB * 12);
        check("bad_leds", leds_o, 16'h1212);
        check_frames("bad_frames");

        // Reset in the middle of an RX frame
        rx_a_i = 1'b0;
        idle(3 * CPB);
        rst_i = 1'b0;
        idle(3);
        check("rxrst_leds", leds_o, 16'h0000);
        check("rxrst_tx", tx_vec, 3'b111);
        rx_a_i = 1'b1;
        idle(2);
        rst_i = 1'b1;
        idle(CPB * 12);
        check("rxrst_after", leds_o, 16'h1000);

        // Reset in the middle of a generated TX frame
        sw_bt_i = 20'h00255; idle(5);
        sw_bt_i = 20'h10255; idle(3);
        sw_bt_i = 20'h00255;
        idle(3 * CPB);
        rst_i = 1'b0;
        idle(2);
        check("txrst_tx", tx_vec, 3'b111);
        rst_i = 1'b1;
        idle(CPB * 12);
        check("txrst_line", tx_vec, 3'b111);
        check_frames("txrst_frames");

        // Sixteen consumed bytes on C: count wraps back to 0
        sw_bt_i = 20'h00200;
        idle(5);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = {4'(i), 4'h2};
            send_frame(3'b100, 8'h00, 8'h00, v, 1'b1);
            idle(4);
            if (i == 0) check("wrap_first", leds_o, 16'h1102);
        end
        check("wrap_leds", leds_o, 16'h10F2);
        check_frames("wrap_frames");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
